// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU).
// Each request becomes one transaction (ADDR then DATA). Only one transaction is
// outstanding at a time. The LSU has fixed priority, with a starvation guard for the IFU.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT        = 64,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req_valid,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_req_ready,
  input  logic            lsu_req_valid,
  input  logic            lsu_req_wen,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_req_ready,
  output logic            ifu_resp_valid,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_rdata,
  output logic            mem_abort,
  output logic            busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q;
  logic            owner_lsu_q;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   streak_q;
  logic            req_valid_q;
  logic            req_wen_q;
  logic [AW-1:0]   req_addr_q;
  logic [DW-1:0]   req_wdata_q;
  logic [DW/8-1:0] req_wmask_q;

  logic idle;
  logic ifu_starved;
  logic ifu_wins;
  logic lsu_wins;
  logic done;
  logic expire;
  logic respond;

  // Readiness is gated by rst_n so a requester holding valid through reset is not accepted.
  assign idle        = rst_n && (state_q == IDLE);
  assign ifu_starved = ifu_req_valid && (streak_q == STREAK_MAX);
  assign lsu_wins    = idle && lsu_req_valid && !ifu_starved;
  assign ifu_wins    = idle && ifu_req_valid && !lsu_wins;

  // Completion takes precedence over a timeout that expires in the same cycle.
  assign done    = (state_q == DATA) && mem_resp_valid;
  assign expire  = (state_q != IDLE) && (cnt_q == CNT_LAST) && !done;
  assign respond = done || expire;

  assign ifu_req_ready  = ifu_wins;
  assign lsu_req_ready  = lsu_wins;
  assign ifu_resp_valid = respond && !owner_lsu_q;
  assign lsu_resp_valid = respond && owner_lsu_q;
  assign resp_rdata     = (done && !req_wen_q) ? mem_resp_rdata : '0;
  assign resp_err       = expire;
  assign mem_abort      = expire;
  assign busy           = (state_q != IDLE);

  assign mem_req_valid = req_valid_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_wins || lsu_wins) begin
            state_q     <= ADDR;
            owner_lsu_q <= lsu_wins;
            cnt_q       <= '0;
            req_valid_q <= 1'b1;
            req_wen_q   <= lsu_wins && lsu_req_wen;
            req_addr_q  <= lsu_wins ? lsu_req_addr : ifu_req_addr;
            req_wdata_q <= lsu_wins ? lsu_req_wdata : '0;
            req_wmask_q <= lsu_wins ? lsu_req_wmask : '0;
            if (lsu_wins && ifu_req_valid) begin
              if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
            end else begin
              streak_q <= '0;
            end
          end
        end
        ADDR: begin
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
          if (expire) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end else if (mem_req_ready) begin
            state_q     <= DATA;
            req_valid_q <= 1'b0;
          end
        end
        DATA: begin
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
          if (respond) state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the basic
// grant/response flow, then scripted streak, timeout and reset-in-flight sequences.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 64;
  localparam int MAXS = 4;
  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h8000_0100;
  localparam logic [31:0] WD = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_req_valid = 1'b0;
  logic [AW-1:0] ifu_req_addr = IA;
  logic          ifu_req_ready;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_wen = 1'b0;
  logic [AW-1:0] lsu_req_addr = LA;
  logic [DW-1:0] lsu_req_wdata = WD;
  logic [3:0]    lsu_req_wmask = 4'hF;
  logic          lsu_req_ready;
  logic          ifu_resp_valid;
  logic          lsu_resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_wmask;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;
  logic          mem_abort;
  logic          busy;

  int total = 0;
  int passed = 0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_LSU_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .lsu_resp_valid(lsu_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_abort(mem_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ifu_v, lsu_v, lsu_wen, mrdy, mresp;
    logic [31:0] mrdata;
    logic        e_ifu_rdy, e_lsu_rdy, e_mvalid, e_ifu_resp, e_lsu_resp, e_err, e_busy, e_wen;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_wmask;
  } vec_t;

  vec_t vt[11];

  task automatic run_timeout(input bit simul);
    int early;
    step();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("to%0d grant", simul), ifu_req_ready, 1'b1);
    early = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      ifu_req_valid = 1'b0;
      mem_req_ready = (k == 1);
      if (simul && k == TIMEOUT) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h600D_CAFE;
      end
      @(negedge clk);
      if (k < TIMEOUT) begin
        if (ifu_resp_valid || lsu_resp_valid || mem_abort) early++;
      end else begin
        chk($sformatf("to%0d ifu_resp", simul), ifu_resp_valid, 1'b1);
        chk($sformatf("to%0d lsu_resp", simul), lsu_resp_valid, 1'b0);
        chk($sformatf("to%0d err", simul), resp_err, simul ? 1'b0 : 1'b1);
        chk($sformatf("to%0d abort", simul), mem_abort, simul ? 1'b0 : 1'b1);
        chk($sformatf("to%0d rdata", simul), resp_rdata, simul ? 32'h600D_CAFE : 32'h0);
      end
    end
    chk($sformatf("to%0d early responses", simul), early, 0);
    step();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("to%0d idle after", simul), busy, 1'b0);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hAAAA_5555;
    @(negedge clk);
    chk($sformatf("to%0d late ifu_resp", simul), ifu_resp_valid, 1'b0);
    chk($sformatf("to%0d late lsu_resp", simul), lsu_resp_valid, 1'b0);
    step();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    logic exp_lsu[10];
    int   n;
    int   cyc;
    bit   rd_done;

    vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        32'h0,32'h0,4'h0};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,        IA,32'h0,4'h0};
    vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hDEAD_BEEF, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 32'hDEAD_BEEF,IA,32'h0,4'h0};
    vt[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        IA,32'h0,4'h0};
    vt[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,        LA,WD,4'hF};
    vt[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h0,        LA,WD,4'hF};
    vt[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,32'hCAFE_F00D, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 32'h0,        LA,WD,4'hF};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0,        LA,WD,4'hF};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h1234_5678, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,        IA,32'h0,4'h0};
    vt[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0BAD_F00D, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0BAD_F00D,IA,32'h0,4'h0};
    vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h7777_7777, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,        IA,32'h0,4'h0};

    // Reset state, with both requesters already asserting valid.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ifu_rdy", ifu_req_ready, 1'b0);
    chk("rst lsu_rdy", lsu_req_ready, 1'b0);
    chk("rst mvalid", mem_req_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst addr", mem_req_addr, 32'h0);
    chk("rst abort", mem_abort, 1'b0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step();
      ifu_req_valid  = vt[i].ifu_v;
      lsu_req_valid  = vt[i].lsu_v;
      lsu_req_wen    = vt[i].lsu_wen;
      mem_req_ready  = vt[i].mrdy;
      mem_resp_valid = vt[i].mresp;
      mem_resp_rdata = vt[i].mrdata;
      @(negedge clk);
      chk($sformatf("row%0d ifu_rdy", i), ifu_req_ready, vt[i].e_ifu_rdy);
      chk($sformatf("row%0d lsu_rdy", i), lsu_req_ready, vt[i].e_lsu_rdy);
      chk($sformatf("row%0d mvalid", i), mem_req_valid, vt[i].e_mvalid);
      chk($sformatf("row%0d ifu_resp", i), ifu_resp_valid, vt[i].e_ifu_resp);
      chk($sformatf("row%0d lsu_resp", i), lsu_resp_valid, vt[i].e_lsu_resp);
      chk($sformatf("row%0d err", i), resp_err, vt[i].e_err);
      chk($sformatf("row%0d abort", i), mem_abort, vt[i].e_err);
      chk($sformatf("row%0d busy", i), busy, vt[i].e_busy);
      chk($sformatf("row%0d wen", i), mem_req_wen, vt[i].e_wen);
      chk($sformatf("row%0d rdata", i), resp_rdata, vt[i].e_rdata);
      chk($sformatf("row%0d addr", i), mem_req_addr, vt[i].e_addr);
      chk($sformatf("row%0d wdata", i), mem_req_wdata, vt[i].e_wdata);
      chk($sformatf("row%0d wmask", i), mem_req_wmask, vt[i].e_wmask);
    end

    // LSU streak versus a continuously waiting IFU.
    exp_lsu = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0};
    step();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_req_wen = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA_55AA;
    n = 0;
    cyc = 0;
    rd_done = 1'b0;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      if (ifu_req_ready || lsu_req_ready) begin
        chk($sformatf("streak grant%0d", n), lsu_req_ready, exp_lsu[n]);
        n++;
      end
      if (lsu_resp_valid && !rd_done) begin
        chk("streak load rdata", resp_rdata, 32'h55AA_55AA);
        rd_done = 1'b1;
      end
      step();
      cyc++;
    end
    chk("streak grant count", n, 10);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (3) step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Reset while a fetch is in DATA; the IFU keeps its request up.
    step();
    ifu_req_valid = 1'b1;
    @(negedge clk);
    chk("rstdata grant", ifu_req_ready, 1'b1);
    step();
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rstdata addr phase", mem_req_valid, 1'b1);
    step();
    mem_req_ready = 1'b0;
    #2;
    chk("rstdata in DATA", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFF_0000;
    #1;
    chk("rstdata busy", busy, 1'b0);
    chk("rstdata mvalid", mem_req_valid, 1'b0);
    chk("rstdata addr", mem_req_addr, 32'h0);
    chk("rstdata ifu_rdy", ifu_req_ready, 1'b0);
    chk("rstdata ifu_resp", ifu_resp_valid, 1'b0);
    chk("rstdata abort", mem_abort, 1'b0);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstdata regrant", ifu_req_ready, 1'b1);
    chk("rstdata no resp", ifu_resp_valid, 1'b0);
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rstdata fresh mvalid", mem_req_valid, 1'b1);
    chk("rstdata fresh addr", mem_req_addr, IA);
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0123_4567;
    @(negedge clk);
    chk("rstdata fresh resp", ifu_resp_valid, 1'b1);
    chk("rstdata fresh rdata", resp_rdata, 32'h0123_4567);
    step();
    mem_resp_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one shared memory port between the instruction-fetch unit (IFU) and the load/store path of the execute unit (LSU).
- Turns each single-beat request into a handshaked transaction on the memory side, with one transaction outstanding at a time.
- Gives the LSU fixed priority, with a starvation guard for the IFU.
- Adds a response timeout with abort.

Parameters:
AW, 32, address width
DW, 32, data width (byte mask width DW/8)
TIMEOUT, 64, cycles from grant until abort with error
MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IFU waits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_addr  in  AW  IFU address
ifu_req_ready  out  1  IFU request accepted this cycle
lsu_req_valid  in  1  LSU request
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_addr  in  AW  LSU address
lsu_req_wdata  in  DW  store data
lsu_req_wmask  in  DW/8  store byte mask
lsu_req_ready  out  1  LSU request accepted this cycle
ifu_resp_valid  out  1  one-cycle response pulse to IFU
lsu_resp_valid  out  1  one-cycle response pulse to LSU
resp_rdata  out  DW  read data for the pulsing requester (0 for stores and errors)
resp_err  out  1  response is a timeout abort
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  registered copy of wen
mem_req_addr  out  AW  registered copy of addr
mem_req_wdata  out  DW  registered copy of wdata
mem_req_wmask  out  DW/8  registered copy of wmask
mem_resp_valid  in  1  memory response
mem_resp_rdata  in  DW  memory read data
mem_abort  out  1  one-cycle pulse; memory drops the outstanding transaction
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0 and state IDLE.
  - Owner, streak and timeout counters cleared.
  - Reset during ADDR or DATA discards the transaction; no response is issued.
- States: IDLE, ADDR, DATA.
- IDLE grant selection:
  - IFU wins if ifu_req_valid and streak==MAX_LSU_STREAK.
  - Otherwise LSU wins if lsu_req_valid.
  - Otherwise IFU wins if ifu_req_valid.
- IDLE grant actions:
  - The winner's *_req_ready is asserted combinationally in the same cycle.
  - Request fields are registered into mem_req_*. IFU grants force wen=0, wdata=0, wmask=0.
  - Owner is recorded; next state is ADDR; timeout counter set to 0.
  - The loser sees ready=0 and must hold its request.
- Streak counter:
  - Increments on an LSU grant while ifu_req_valid=1, saturating at MAX_LSU_STREAK.
  - Clears on an IFU grant, or on an LSU grant with ifu_req_valid=0.
- ADDR:
  - mem_req_valid=1 with stable fields.
  - On mem_req_ready=1 go to DATA.
- DATA:
  - mem_req_valid=0.
  - On mem_resp_valid=1: owner's resp_valid pulses for one cycle; resp_rdata = mem_resp_rdata for loads/fetches, 0 for stores; resp_err=0; next state IDLE.
- mem_resp_valid in IDLE or ADDR is ignored.
- Timeout:
  - The counter increments every cycle in ADDR or DATA.
  - When it reaches TIMEOUT-1 with no completion that cycle: owner's resp_valid=1, resp_err=1, resp_rdata=0, mem_abort=1, next state IDLE. mem_req_valid drops immediately.
  - If completion and timeout fall in the same cycle, completion wins (err=0, no abort).
- Responses are combinational from state and the memory inputs. All other mem_* outputs are registered.
- Throughput:
  - Minimum 3 cycles per transaction (grant, ADDR with ready, DATA with resp).
  - The next grant happens no earlier than the cycle after the response.
- Exactly one outstanding transaction; *_req_ready is never asserted outside IDLE.
- Width rules: the timeout counter is clog2(TIMEOUT) bits and never wraps; the streak counter saturates.

Test Plan:
- Reset then lone IFU read at 0x8000_0000: ifu_req_ready pulses cycle 0, mem_req_valid cycle 1, memory readies immediately and responds 0xDEAD_BEEF a cycle later -> ifu_resp_valid=1, resp_rdata=0xDEADBEEF, resp_err=0; busy high for 2 cycles.
- IFU and LSU store (addr 0x8000_0100, wdata 0x1234_5678, wmask 0xF) raised together -> LSU granted first with mem_req_wen=1 and fields matching; lsu_resp_valid with rdata 0; IFU granted in the cycle after the LSU response.
- IFU valid continuously, LSU issuing back-to-back loads, MAX_LSU_STREAK=4 -> exactly 4 LSU grants, then 1 IFU grant, then LSU resumes; streak reads 0 after the IFU grant.
- Memory never asserts mem_resp_valid, TIMEOUT=64 -> owner resp pulse with resp_err=1 and mem_abort=1 exactly 64 cycles after grant; next state IDLE; a late mem_resp_valid in IDLE produces no response.
- mem_resp_valid arrives in the same cycle the timeout expires -> normal response, resp_err=0, mem_abort=0.
- rst_n asserted low while in DATA -> all outputs 0 asynchronously; after release no *_resp_valid pulse and the pending requester is re-granted fresh.
